param_pattern_detector: RTL and testbench
=========================================

// Module: param_pattern_detector
// PURPOSE
//   Serial pattern detector with a runtime-programmable pattern, length and don't-care mask.
//   Each valid input bit is shifted into a history window and compared against the pattern.
//   Overlapping or non-overlapping detection is selectable.
//   Sits on a valid-qualified serial bit stream and feeds a 1-cycle detect pulse plus a
//   saturating match counter to downstream control/status logic.
// PARAMETERS
//   MAX_LEN     8           widest supported pattern (bits), >=2
//   CNT_W       8           match counter width
//   DEF_PATTERN 8'b0000_0110 pattern loaded at reset (LSB-aligned)
//   DEF_LEN     4           pattern length loaded at reset, 1..MAX_LEN
//   DEF_OVL     1           overlap mode loaded at reset (1=overlapping)
// PORTS
//   clk           in   1                      clock, rising edge
//   rst           in   1                      asynchronous, active-high reset
//   d_i           in   1                      serial data bit
//   v_i           in   1                      d_i valid; bit consumed only when 1
//   cfg_we        in   1                      load cfg_* this cycle
//   cfg_pattern   in   MAX_LEN                pattern; bit [len-1] is oldest/first bit, [0] newest
//   cfg_mask      in   MAX_LEN                1=compare bit, 0=don't care
//   cfg_len       in   $clog2(MAX_LEN+1)      pattern length
//   cfg_ovl       in   1                      1=overlapping, 0=non-overlapping
//   cnt_clr       in   1                      synchronous clear of match_count
//   pattern_detect out 1                      1-cycle pulse per match
//   match_count   out CNT_W                   saturating count of matches
//   cfg_err       out 1                       1-cycle pulse: cfg_we rejected
// BEHAVIOUR
//   Reset: pattern/mask/len/ovl <= DEF_PATTERN/all-ones/DEF_LEN/DEF_OVL.
//     hist<=0, fill<=0, state<=FILL.
//     pattern_detect=0, match_count=0, cfg_err=0.
//   Accepted bit (v_i=1, cfg_we=0):
//     hist <= {hist[MAX_LEN-2:0], d_i}.
//     fill <= min(fill+1, MAX_LEN).
//   v_i=0: hist, fill and state are held; d_i is ignored.
//   Match = accepted bit AND fill_next>=len AND ((hist_next ^ pattern) & mask & lenmask)==0.
//     lenmask = (1<<len)-1.
//   Latency: pattern_detect is registered. It is high for exactly the one cycle after the edge
//     that sampled the final pattern bit.
//   FSM, two states:
//     FILL: fewer than len valid bits are held; match impossible. -> HUNT when fill_next>=len.
//     HUNT: compare on every accepted bit.
//       On match with ovl=1: stay in HUNT; history is kept, so a suffix can start the next match.
//       On match with ovl=0: fill<=0, hist<=0, -> FILL; no bit is reused.
//   cfg_we:
//     Valid only when 1<=cfg_len<=MAX_LEN. Loads all cfg_* and clears hist/fill; -> FILL.
//     Any bit presented in the same cycle is dropped, and no detect is generated that cycle.
//   Invalid cfg_len (0 or >MAX_LEN): config is unchanged, history is untouched,
//     cfg_err pulses 1 cycle.
//   match_count: +1 per detect pulse; saturates at 2^CNT_W-1 with no wrap.
//     cnt_clr has priority over a simultaneous increment (result 0).
//   Reset asserted mid-stream: all outputs go to their reset values immediately, asynchronously.
//     A partial match in progress is discarded.
//   Mask bits above len are ignored; mask=0 within len matches any len bits once fill>=len.
// STRUCTURE
//   pattern_det_defs.vh (shared include): state encodings ST_FILL/ST_HUNT; helper localparam
//     for the cfg_len width.
//   One sub-module: sat_counter #(CNT_W) (inc, clr, count), reused by other detector variants.
//   Compare logic stays inline; there is no other hierarchy.
// TESTING
//   1 Defaults (0110, len4, ovl). Stream 0,1,1,0,1,1,0 all valid
//     -> detect after bits 4 and 7; match_count=2.
//   2 cfg 0110/len4/ovl=0. Stream 0,1,1,0,1,1,0 -> one detect (bit 4); count=1.
//     Then 0,1,1,0 -> second detect; count=2.
//   3 Defaults, stream 0,1,1,0 with v_i=0 for 3 cycles between bits 2 and 3,
//     and d_i toggling while invalid -> exactly one detect, 1 cycle after the 4th valid bit.
//   4 cfg pattern 1101, mask 1011, len4.
//     Stream 1,0,0,1 -> detect. Stream 1,1,0,1 -> detect. Stream 1,0,1,1 -> none.
//   5 cfg_len=9 (MAX_LEN=8) -> cfg_err pulse, 0110 still detected.
//     cfg_we together with v_i=1 -> that bit dropped, and fill restarts.
//   6 CNT_W=2: 5 matches -> match_count=3, held.
//     cnt_clr on a detect cycle -> count 0.
//     rst after 3 bits of 0110 -> outputs 0; the next full 0110 detects normally.

Source files
------------

// File: rtl/param_pattern_detector_pkg.sv
// rtl/param_pattern_detector_pkg.sv - shared FSM encoding and width helper for the pattern detector
package param_pattern_detector_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HUNT = 1'b1
  } state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/param_pattern_detector_sat_counter.sv
// rtl/param_pattern_detector_sat_counter.sv - saturating event counter with clear priority
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/param_pattern_detector.sv
// rtl/param_pattern_detector.sv - serial pattern detector with programmable pattern, length, mask and overlap
module param_pattern_detector
  import param_pattern_detector_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b0110,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVL     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           d_i,
  input  logic                           v_i,
  input  logic                           cfg_we,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [MAX_LEN-1:0]             cfg_mask,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_ovl,
  input  logic                           cnt_clr,
  output logic                           pattern_detect,
  output logic [CNT_W-1:0]               match_count,
  output logic                           cfg_err
);

  localparam int            LW    = len_w(MAX_LEN);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      len;
  logic               ovl;
  logic [MAX_LEN-1:0] hist;
  logic [LW-1:0]      fill;
  state_t             state;

  logic               accept;
  logic               len_ok;
  logic [MAX_LEN-1:0] hist_next;
  logic [LW-1:0]      fill_next;
  logic [MAX_LEN-1:0] lenmask;
  logic               window_full;
  logic               match;

  always_comb begin
    accept    = v_i & ~cfg_we;
    len_ok    = (cfg_len != '0) && (cfg_len <= MAX_L);
    hist_next = {hist[MAX_LEN-2:0], d_i};
    fill_next = (fill == MAX_L) ? MAX_L : fill + LW'(1);
    lenmask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      lenmask[i] = (i < int'(len));
    end
    // HUNT already guarantees a full window; FILL needs the incoming bit to complete it
    window_full = (state == ST_HUNT) || (fill_next >= len);
    match       = accept && window_full &&
                  (((hist_next ^ pattern) & mask & lenmask) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern        <= DEF_PATTERN;
      mask           <= '1;
      len            <= LW'(DEF_LEN);
      ovl            <= DEF_OVL;
      hist           <= '0;
      fill           <= '0;
      state          <= ST_FILL;
      pattern_detect <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      pattern_detect <= match;
      cfg_err        <= cfg_we && !len_ok;
      if (cfg_we) begin
        if (len_ok) begin
          pattern <= cfg_pattern;
          mask    <= cfg_mask;
          len     <= cfg_len;
          ovl     <= cfg_ovl;
          hist    <= '0;
          fill    <= '0;
          state   <= ST_FILL;
        end
      end else if (v_i) begin
        if (match && !ovl) begin
          hist  <= '0;
          fill  <= '0;
          state <= ST_FILL;
        end else begin
          hist <= hist_next;
          fill <= fill_next;
          if (fill_next >= len) state <= ST_HUNT;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pattern_detect),
    .clr   (cnt_clr),
    .count (match_count)
  );

endmodule

// File: tb/tb_param_pattern_detector.sv
// tb/tb_param_pattern_detector.sv - directed-vector bench for param_pattern_detector
module tb_param_pattern_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_i, v_i, cfg_we, cfg_ovl, cnt_clr;
  logic [7:0] cfg_pattern, cfg_mask;
  logic [3:0] cfg_len;
  logic       det1, err1, det2, err2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_pattern_detector u_dut (
    .clk(clk), .rst(rst), .d_i(d_i), .v_i(v_i), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .pattern_detect(det1), .match_count(cnt1), .cfg_err(err1)
  );

  param_pattern_detector #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .d_i(d_i), .v_i(v_i), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .pattern_detect(det2), .match_count(cnt2), .cfg_err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic v);
    d_i = d;
    v_i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0);
  endtask

  task automatic run(input string tag, input logic [31:0] bits, input int n, input logic [31:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1);
      chk($sformatf("%s det bit%0d", tag, n - i), {31'd0, det1}, {31'd0, exp[i]});
    end
  endtask

  task automatic cfg(input string tag, input logic [7:0] pat, input logic [7:0] msk,
                     input logic [3:0] len, input logic ovl, input logic v, input logic d,
                     input logic exp_err);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_len     = len;
    cfg_ovl     = ovl;
    step(d, v);
    cfg_we = 1'b0;
    chk({tag, " cfg_err"}, {31'd0, err1}, {31'd0, exp_err});
    chk({tag, " cfg det"}, {31'd0, det1}, 32'd0);
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    idle();
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; d_i = 1'b0; v_i = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = '0; cfg_mask = '0; cfg_len = '0; cfg_ovl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset det", {31'd0, det1}, 32'd0);
    chk("reset cnt", {24'd0, cnt1}, 32'd0);
    chk("reset err", {31'd0, err1}, 32'd0);
    rst = 1'b0;

    // defaults, overlapping
    run("t1", 32'b0110110, 7, 32'b0001001);
    idle();
    chk("t1 det low", {31'd0, det1}, 32'd0);
    chk("t1 cnt", {24'd0, cnt1}, 32'd2);

    // non-overlapping
    clear_cnt();
    cfg("t2", 8'h06, 8'hFF, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    run("t2a", 32'b0110110, 7, 32'b0001000);
    idle();
    chk("t2 cnt1", {24'd0, cnt1}, 32'd1);
    run("t2b", 32'b0110, 4, 32'b0001);
    idle();
    chk("t2 cnt2", {24'd0, cnt1}, 32'd2);

    // invalid cycles in the middle of a pattern
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b1); chk("t3 b1", {31'd0, det1}, 32'd0);
    step(1'b1, 1'b1); chk("t3 b2", {31'd0, det1}, 32'd0);
    step(1'b1, 1'b0); chk("t3 gap1", {31'd0, det1}, 32'd0);
    step(1'b0, 1'b0); chk("t3 gap2", {31'd0, det1}, 32'd0);
    step(1'b1, 1'b0); chk("t3 gap3", {31'd0, det1}, 32'd0);
    step(1'b1, 1'b1); chk("t3 b3", {31'd0, det1}, 32'd0);
    step(1'b0, 1'b1); chk("t3 b4", {31'd0, det1}, 32'd1);
    idle();           chk("t3 pulse end", {31'd0, det1}, 32'd0);

    // don't-care mask
    cfg("t4", 8'h0D, 8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    run("t4a", 32'b1001, 4, 32'b0001);
    run("t4b", 32'b1101, 4, 32'b0001);
    run("t4c", 32'b1011, 4, 32'b0000);
    cfg("t4z", 8'h00, 8'h00, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    run("t4z", 32'b101, 3, 32'b011);

    // bad length rejected, config update drops the concurrent bit
    cfg("t5", 8'hF6, 8'hFF, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    run("t5a", 32'b011, 3, 32'b000);
    cfg("t5bad", 8'h00, 8'h00, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("t5 err pulse end", {31'd0, err1}, 32'd0);
    chk("t5 kept history", {31'd0, det1}, 32'd1);
    run("t5b", 32'b011, 3, 32'b000);
    cfg("t5drop", 8'hF6, 8'hFF, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    run("t5c", 32'b0110, 4, 32'b0001);

    // saturation, clear priority, mid-stream reset
    clear_cnt();
    run("t6a", 32'b0110110110110110, 16, 32'b0001001001001001);
    idle();
    chk("t6 cnt8", {24'd0, cnt1}, 32'd5);
    chk("t6 cnt2 sat", {30'd0, cnt2}, 32'd3);
    idle();
    chk("t6 cnt2 held", {30'd0, cnt2}, 32'd3);
    run("t6b", 32'b0110, 4, 32'b0001);
    clear_cnt();
    chk("t6 clr prio8", {24'd0, cnt1}, 32'd0);
    chk("t6 clr prio2", {30'd0, cnt2}, 32'd0);
    run("t6c", 32'b0110, 4, 32'b0001);
    idle();
    chk("t6 cnt after clr", {24'd0, cnt1}, 32'd1);
    run("t6d", 32'b011, 3, 32'b000);
    #1 rst = 1'b1;
    #1;
    chk("t6 async det", {31'd0, det1}, 32'd0);
    chk("t6 async cnt8", {24'd0, cnt1}, 32'd0);
    chk("t6 async cnt2", {30'd0, cnt2}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run("t6e", 32'b0110, 4, 32'b0001);
    idle();
    chk("t6 final cnt", {24'd0, cnt1}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
